// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3
//   Builds the 3x3 neighbourhood z0..z8 of a raster 8-bit grey pixel stream
//   for the Sobel edge stage. Two line buffers hold the previous two rows,
//   and three 3-deep column shift registers form the window.
//   Layout: z0..z2 = row r-2, z3..z5 = row r-1, z6..z8 = row r (current).
//   Within a row, column increases left to right (z8 = newest pixel).
//
// Parameters
//   WIDTH  pixels per line (line-buffer depth); columns >= WIDTH are dropped
//   XW     column counter / center_x width, 2**XW >= WIDTH
//   YW     row counter / center_y width; row count saturates at 2**YW-1
//
// Ports
//   clock, reset_n          single clock, asynchronous active-low reset
//   pixel_valid, pixel_in   pixel stream (pixel_in qualified by pixel_valid)
//   line_start, frame_start first pixel of line / frame (frame wins)
//   z0..z8                  registered window pixels
//   window_valid            one-cycle strobe: z0..z8 are a complete window
//   center_x, center_y      coordinate of z4
//
// Optional feature, macro WIN_OVF_EN:
//   ovf_flag   sticky flag, set by any dropped (overlong-line) pixel
//   ovf_count  saturating count of dropped pixels
//   Both cleared by reset and by an accepted frame_start.

module sobel_window_3x3 #(
  parameter int WIDTH = 640,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pixel_valid,
  input  logic [7:0]    pixel_in,
  input  logic          line_start,
  input  logic          frame_start,
  output logic [7:0]    z0,
  output logic [7:0]    z1,
  output logic [7:0]    z2,
  output logic [7:0]    z3,
  output logic [7:0]    z4,
  output logic [7:0]    z5,
  output logic [7:0]    z6,
  output logic [7:0]    z7,
  output logic [7:0]    z8,
  output logic          window_valid,
  output logic [XW-1:0] center_x,
  output logic [YW-1:0] center_y
`ifdef WIN_OVF_EN
  ,
  output logic          ovf_flag,
  output logic [15:0]   ovf_count
`endif
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // One extra bit so the column counter can hold WIDTH itself (the "full" state).
  localparam int CW = XW + 1;
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [YW-1:0] ROW_MAX = '1;

  logic [7:0] lb0 [WIDTH];
  logic [7:0] lb1 [WIDTH];

  logic [CW-1:0]      col_q, col_d;
  logic [YW-1:0]      row_q, row_d;
  logic [8:0][7:0]    z_q, z_d;
  logic               window_valid_q, window_valid_d;
  logic [XW-1:0]      center_x_q, center_x_d;
  logic [YW-1:0]      center_y_q, center_y_d;

  logic               start;
  logic               accept;
  logic [CW-1:0]      c;
  logic [YW-1:0]      r;
  logic [AW-1:0]      idx;
  logic [7:0]         top;
  logic [7:0]         mid;

  always_comb begin
    start  = line_start | frame_start;
    // A start pixel is always accepted, even if the previous line overran.
    accept = pixel_valid & (start | (col_q < WIDTH_C));
    c      = start ? '0 : col_q;

    if (frame_start)     r = '0;
    else if (line_start) r = (row_q == ROW_MAX) ? row_q : row_q + YW'(1);
    else                 r = row_q;

    idx = accept ? AW'(c) : '0;
    // Asynchronous read of the old contents; the write lands at the clock edge.
    top = lb0[idx];
    mid = lb1[idx];

    col_d          = col_q;
    row_d          = row_q;
    z_d            = z_q;
    window_valid_d = 1'b0;
    center_x_d     = center_x_q;
    center_y_d     = center_y_q;

    if (accept) begin
      col_d  = start ? CW'(1) : col_q + CW'(1);
      row_d  = r;
      z_d[0] = z_q[1];
      z_d[1] = z_q[2];
      z_d[2] = top;
      z_d[3] = z_q[4];
      z_d[4] = z_q[5];
      z_d[5] = mid;
      z_d[6] = z_q[7];
      z_d[7] = z_q[8];
      z_d[8] = pixel_in;
      // No padding: the first two rows and columns never form a window.
      window_valid_d = (r >= YW'(2)) && (c >= CW'(2));
      center_x_d     = XW'(c - CW'(1));
      center_y_d     = r - YW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q          <= '0;
      row_q          <= '0;
      z_q            <= '0;
      window_valid_q <= 1'b0;
      center_x_q     <= '0;
      center_y_q     <= '0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      z_q            <= z_d;
      window_valid_q <= window_valid_d;
      center_x_q     <= center_x_d;
      center_y_q     <= center_y_d;
    end
  end

  // Line buffers are never cleared; stale entries are hidden by the row >= 2 gate.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb0[idx] <= mid;
      lb1[idx] <= pixel_in;
    end
  end

`ifdef WIN_OVF_EN
  logic        drop;
  logic        ovf_flag_q, ovf_flag_d;
  logic [15:0] ovf_count_q, ovf_count_d;

  always_comb begin
    drop        = pixel_valid & ~start & (col_q >= WIDTH_C);
    ovf_flag_d  = ovf_flag_q;
    ovf_count_d = ovf_count_q;
    if (accept && frame_start) begin
      ovf_flag_d  = 1'b0;
      ovf_count_d = '0;
    end else if (drop) begin
      ovf_flag_d  = 1'b1;
      ovf_count_d = (ovf_count_q == 16'hFFFF) ? ovf_count_q : ovf_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_flag_q  <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      ovf_flag_q  <= ovf_flag_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_flag  = ovf_flag_q;
  assign ovf_count = ovf_count_q;
`endif

  assign z0           = z_q[0];
  assign z1           = z_q[1];
  assign z2           = z_q[2];
  assign z3           = z_q[3];
  assign z4           = z_q[4];
  assign z5           = z_q[5];
  assign z6           = z_q[6];
  assign z7           = z_q[7];
  assign z8           = z_q[8];
  assign window_valid = window_valid_q;
  assign center_x     = center_x_q;
  assign center_y     = center_y_q;

endmodule

// File: tb/tb_sobel_window_3x3.sv
module tb_sobel_window_3x3;

  localparam int W = 8;

  logic       clock;
  logic       reset_n;
  logic       pixel_valid;
  logic [7:0] pixel_in;
  logic       line_start;
  logic       frame_start;

  logic [7:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic       window_valid;
  logic [2:0] center_x;
  logic [8:0] center_y;

  logic [7:0] q0, q1, q2, q3, q4, q5, q6, q7, q8;
  logic       window_valid2;
  logic [2:0] center_x2;
  logic [1:0] center_y2;

`ifdef WIN_OVF_EN
  logic        ovf_flag, ovf_flag2;
  logic [15:0] ovf_count, ovf_count2;
`endif

  sobel_window_3x3 #(.WIDTH(W), .XW(3), .YW(9)) dut (
    .clock(clock), .reset_n(reset_n), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .line_start(line_start), .frame_start(frame_start),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7), .z8(z8),
    .window_valid(window_valid), .center_x(center_x), .center_y(center_y)
`ifdef WIN_OVF_EN
    , .ovf_flag(ovf_flag), .ovf_count(ovf_count)
`endif
  );

  // Second instance with a tiny row counter to exercise row saturation.
  sobel_window_3x3 #(.WIDTH(W), .XW(3), .YW(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .line_start(line_start), .frame_start(frame_start),
    .z0(q0), .z1(q1), .z2(q2), .z3(q3), .z4(q4), .z5(q5), .z6(q6), .z7(q7), .z8(q8),
    .window_valid(window_valid2), .center_x(center_x2), .center_y(center_y2)
`ifdef WIN_OVF_EN
    , .ovf_flag(ovf_flag2), .ovf_count(ovf_count2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int consec = 0;
  int prev_wv = 0;

  // Reference model: image position, plus per-column history of the two most
  // recent pixels written in that column (what the previous lines left behind).
  int m_col, m_raw, m_ovf, m_flag;
  int prev_line[$], last_line[$];
  int col_top[$], col_mid[$], col_cur[$];
  int e_wv, e_cx, e_r;
  int e_z[$];

  typedef struct {
    logic [7:0] pix;
    logic       ls;
    logic       fs;
    logic       wv;
    int         cx;
    int         cy;
  } vec_t;
  vec_t tbl[$];
  int   tbl_z[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dut_z(input int k);
    case (k)
      0: return int'(z0);
      1: return int'(z1);
      2: return int'(z2);
      3: return int'(z3);
      4: return int'(z4);
      5: return int'(z5);
      6: return int'(z6);
      7: return int'(z7);
      default: return int'(z8);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [7:0] p, input logic ls, input logic fs);
    int c;
    int raw;
    bit acc;
    pixel_valid = v;
    pixel_in    = p;
    line_start  = ls;
    frame_start = fs;
    @(posedge clock);
    e_wv = 0;
    acc  = v && (ls || fs || m_col < W);
    if (v && !ls && !fs && m_col >= W) begin
      m_flag = 1;
      if (m_ovf < 65535) m_ovf++;
    end
    if (acc) begin
      c   = (ls || fs) ? 0 : m_col;
      raw = fs ? 0 : (ls ? m_raw + 1 : m_raw);
      if (fs) begin
        m_ovf  = 0;
        m_flag = 0;
      end
      col_top[c] = prev_line[c];
      col_mid[c] = last_line[c];
      col_cur[c] = int'(p);
      prev_line[c] = last_line[c];
      last_line[c] = int'(p);
      m_col = c + 1;
      m_raw = raw;
      if (raw >= 2 && c >= 2) begin
        e_wv = 1;
        for (int k = 0; k < 3; k++) begin
          e_z[k]     = col_top[c - 2 + k];
          e_z[k + 3] = col_mid[c - 2 + k];
          e_z[k + 6] = col_cur[c - 2 + k];
        end
        e_cx = c - 1;
        e_r  = raw;
      end
    end
    #1;
    chk("window_valid", int'(window_valid), e_wv);
    chk("window_valid_yw2", int'(window_valid2), e_wv);
    if (e_wv != 0) begin
      for (int k = 0; k < 9; k++) chk($sformatf("z%0d", k), dut_z(k), e_z[k]);
      chk("center_x", int'(center_x), e_cx);
      chk("center_y", int'(center_y), ((e_r > 511) ? 511 : e_r) - 1);
      chk("center_y_yw2", int'(center_y2), ((e_r > 3) ? 3 : e_r) - 1);
    end
`ifdef WIN_OVF_EN
    chk("ovf_flag", int'(ovf_flag), m_flag);
    chk("ovf_count", int'(ovf_count), m_ovf);
`endif
    if (window_valid && prev_wv != 0) consec++;
    prev_wv = int'(window_valid);
    if (window_valid) strobes++;
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 9; k++) chk($sformatf("%s_z%0d", tag, k), dut_z(k), 0);
    chk({tag, "_wv"}, int'(window_valid), 0);
    chk({tag, "_cx"}, int'(center_x), 0);
    chk({tag, "_cy"}, int'(center_y), 0);
    chk({tag, "_wv_yw2"}, int'(window_valid2), 0);
    chk({tag, "_cy_yw2"}, int'(center_y2), 0);
`ifdef WIN_OVF_EN
    chk({tag, "_ovf_flag"}, int'(ovf_flag), 0);
    chk({tag, "_ovf_count"}, int'(ovf_count), 0);
`endif
  endtask

  task automatic model_reset();
    m_col  = 0;
    m_raw  = 0;
    m_ovf  = 0;
    m_flag = 0;
    prev_wv = 0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b1, tbl[i].pix, tbl[i].ls, tbl[i].fs);
      chk({tag, "_wv"}, int'(window_valid), int'(tbl[i].wv));
      if (tbl[i].wv) begin
        for (int k = 0; k < 9; k++) chk($sformatf("%s_z%0d", tag, k), dut_z(k), tbl_z[i * 9 + k]);
        chk({tag, "_cx"}, int'(center_x), tbl[i].cx);
        chk({tag, "_cy"}, int'(center_y), tbl[i].cy);
      end
    end
  endtask

  // Full frame of given height, pixel = base + row*16 + col, optional idle gap after each pixel.
  task automatic send_frame(input int rows, input int base, input bit gaps);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++) begin
        drive(1'b1, 8'(base + r * 16 + c), c == 0, r == 0 && c == 0);
        if (gaps) drive(1'b0, 8'h00, 1'b0, 1'b0);
      end
  endtask

  initial begin
    int s0;
    int len;
    vec_t v;

    for (int i = 0; i < W; i++) begin
      prev_line.push_back(0); last_line.push_back(0);
      col_top.push_back(0); col_mid.push_back(0); col_cur.push_back(0);
    end
    for (int k = 0; k < 9; k++) e_z.push_back(0);

    // Scenario-1 vectors: 8x4 frame, pixel = row*16+col.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        v.pix = 8'(r * 16 + c);
        v.ls  = (c == 0);
        v.fs  = (r == 0 && c == 0);
        v.wv  = (r >= 2 && c >= 2);
        v.cx  = c - 1;
        v.cy  = r - 1;
        tbl.push_back(v);
        for (int k = 0; k < 9; k++)
          tbl_z.push_back(v.wv ? (r - 2 + k / 3) * 16 + (c - 2 + k % 3) : 0);
      end

    reset_n = 1'b1;
    pixel_valid = 1'b0; pixel_in = 8'h00; line_start = 1'b0; frame_start = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    #1 check_zero("reset");
    @(posedge clock);
    #1 reset_n = 1'b1;

    // 1: basic frame
    s0 = strobes;
    run_table("frame1");
    chk("frame1_strobes", strobes - s0, 12);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // 2: same frame with pixel_valid toggling
    s0 = strobes; consec = 0;
    send_frame(4, 0, 1'b1);
    chk("toggle_strobes", strobes - s0, 12);
    chk("toggle_consecutive", consec, 0);

    // 3: overlong line (row 1 has 10 pixels)
    s0 = strobes;
    for (int r = 0; r < 4; r++) begin
      len = (r == 1) ? 10 : W;
      for (int c = 0; c < len; c++)
        drive(1'b1, (c >= W) ? 8'hEE : 8'(r * 16 + c), c == 0, r == 0 && c == 0);
    end
    chk("overlong_strobes", strobes - s0, 12);
`ifdef WIN_OVF_EN
    chk("overlong_flag", int'(ovf_flag), 1);
    chk("overlong_count", int'(ovf_count), 2);
`endif

    // 4: frame_start at row 3, col 4
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < ((r == 3) ? 4 : W); c++)
        drive(1'b1, 8'(8'h40 + r * 16 + c), c == 0, r == 0 && c == 0);
    s0 = strobes;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++)
        drive(1'b1, 8'(8'h80 + r * 16 + c), c == 0, r == 0 && c == 0);
    chk("restart_rows01_strobes", strobes - s0, 0);
    drive(1'b1, 8'hA0, 1'b1, 1'b0);
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    chk("restart_first_wv", int'(window_valid), 1);
    chk("restart_first_z0", int'(z0), 8'h80);
    chk("restart_first_z8", int'(z8), 8'hA2);
    chk("restart_first_cy", int'(center_y), 1);

    // 5: async reset mid-row, then scenario 1 reproduced
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 2) ? 5 : W); c++)
        drive(1'b1, 8'(8'h30 + r * 16 + c), c == 0, r == 0 && c == 0);
    pixel_valid = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    reset_n = 1'b0;
    #1 check_zero("midreset");
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    s0 = strobes;
    run_table("after_reset");
    chk("after_reset_strobes", strobes - s0, 12);

    // 6: 6 rows, YW=2 instance saturates center_y at 2
    s0 = strobes;
    send_frame(6, 5, 1'b0);
    chk("tall_strobes", strobes - s0, 24);
    chk("tall_last_cy_yw2", int'(center_y2), 2);
    chk("tall_last_cy", int'(center_y), 4);
    chk("tall_last_wv_yw2", int'(window_valid2), 1);

    // 7: randomized stream with gaps, short/long lines and stray frame starts
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 5; r++) begin
        len = int'($urandom_range(10, 5));
        for (int c = 0; c < len; c++) begin
          if ($urandom_range(3, 0) == 0) drive(1'b0, 8'($urandom), 1'b0, 1'b0);
          drive(1'b1, 8'($urandom), c == 0,
                (r == 0 && c == 0) || ($urandom_range(63, 0) == 0));
        end
      end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
